// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM access arbiter: FSM states,
// requester ids, read-tag record and round-robin winner selection.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_ARB_IDLE   = 2'd0,
        S_ARB_OWN    = 2'd1,
        S_ARB_SWITCH = 2'd2
    } arb_state_type;

    localparam int REQ_VGA  = 0;
    localparam int REQ_UART = 1;
    localparam int REQ_DEC  = 2;

    typedef logic [1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } read_tag_t;

    function automatic req_id_t onehot_to_id(input logic [2:0] vec);
        req_id_t id;
        id = '0;
        for (int k = 0; k < 3; k++) begin
            if (vec[k]) begin
                id = req_id_t'(k);
            end
        end
        return id;
    endfunction

    // One-hot winner: VGA first when prioritised, otherwise round-robin
    // starting at the requester after last_owner. Zero when nobody asks.
    function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                           input req_id_t  last_owner,
                                           input logic     vga_first);
        logic [2:0] win;
        req_id_t    cand;
        win = '0;
        if (vga_first && req[REQ_VGA]) begin
            win[REQ_VGA] = 1'b1;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                cand = req_id_t'((int'(last_owner) + k) % 3);
                if ((win == 3'b000) && req[cand]) begin
                    win[cand] = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side and SRAM_Controller-side signals of the SRAM access arbiter.
// The arbiter uses the slave modport; requesters/controller the master one.
interface sram_arb_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic [2:0]             Req;
    logic [2:0][ADDR_W-1:0] Address;
    logic [2:0]             We_n;
    logic [2:0][DATA_W-1:0] Write_data;
    logic [2:0]             Grant;
    logic [2:0]             Read_valid;
    logic [DATA_W-1:0]      Read_data;
    logic [ADDR_W-1:0]      SRAM_address;
    logic [DATA_W-1:0]      SRAM_write_data;
    logic                   SRAM_we_n;
    logic [DATA_W-1:0]      SRAM_read_data;

    modport slave (
        input  Req, Address, We_n, Write_data, SRAM_read_data,
        output Grant, Read_valid, Read_data, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport master (
        output Req, Address, We_n, Write_data, SRAM_read_data,
        input  Grant, Read_valid, Read_data, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/sram_read_tag_pipe.sv
// Fixed-depth shift register of {valid, requester id} that lines up each read
// access with the SRAM data returning DEPTH cycles later; srst flushes it.
module sram_read_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    srst,
    input  logic    push_valid,
    input  req_id_t push_id,
    output logic    pop_valid,
    output req_id_t pop_id
);

    read_tag_t [DEPTH-1:0] tag_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            tag_reg <= '0;
        end else begin
            tag_reg[0] <= '{valid: push_valid, id: push_id};
            for (int i = 1; i < DEPTH; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    assign pop_valid = tag_reg[DEPTH-1].valid;
    assign pop_id    = tag_reg[DEPTH-1].id;

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the single-port SRAM among VGA, UART and decoder requesters with burst
// limiting, a turnaround cycle on owner change and tagged read return.
// Optional macro ARB_VGA_PREEMPT_EN: VGA always wins, preempts, ignores burst limit.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    sram_arb_if.slave  bus
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

`ifdef ARB_VGA_PREEMPT_EN
    localparam logic VGA_PRIORITY = 1'b1;
`else
    localparam logic VGA_PRIORITY = 1'b0;
`endif

    arb_state_type    state_reg, state_next;
    logic [2:0]       grant_reg, grant_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    req_id_t          last_owner_reg, last_owner_next;

    logic [2:0]             access_vec;
    logic                   access;
    req_id_t                owner_id;
    logic                   others_pending;
    logic                   burst_exempt;
    logic                   preempt;
    logic [2:0]             winner_vec;
    logic [2:0][ADDR_W-1:0] addr_masked;
    logic [2:0][DATA_W-1:0] wdata_masked;
    logic [2:0]             write_vec;
    logic [2:0]             read_vec;
    logic                   pop_valid;
    req_id_t                pop_id;

    assign access_vec     = grant_reg & bus.Req;
    assign access         = |access_vec;
    assign owner_id       = onehot_to_id(grant_reg);
    assign others_pending = |(bus.Req & ~grant_reg);
    assign burst_exempt   = VGA_PRIORITY & grant_reg[REQ_VGA];
    assign preempt        = VGA_PRIORITY & bus.Req[REQ_VGA] & ~grant_reg[REQ_VGA];
    assign winner_vec     = rr_pick(bus.Req, last_owner_reg, VGA_PRIORITY);

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        burst_cnt_next  = burst_cnt_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            // Grant is zero in both; they differ only in how they were entered.
            S_ARB_IDLE, S_ARB_SWITCH: begin
                grant_next     = winner_vec;
                burst_cnt_next = '0;
                if (|winner_vec) begin
                    state_next      = S_ARB_OWN;
                    last_owner_next = onehot_to_id(winner_vec);
                end else begin
                    state_next = S_ARB_IDLE;
                end
            end
            S_ARB_OWN: begin
                if (!access) begin
                    grant_next = '0;
                    state_next = (|bus.Req) ? S_ARB_SWITCH : S_ARB_IDLE;
                end else begin
                    if (burst_cnt_reg != BURST_LAST) begin
                        burst_cnt_next = burst_cnt_reg + CNT_W'(1);
                    end
                    if ((burst_cnt_reg == BURST_LAST && others_pending && !burst_exempt)
                            || preempt) begin
                        grant_next = '0;
                        state_next = S_ARB_SWITCH;
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = S_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg      <= S_ARB_IDLE;
            grant_reg      <= '0;
            burst_cnt_reg  <= '0;
            last_owner_reg <= req_id_t'(REQ_DEC);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            burst_cnt_reg  <= burst_cnt_next;
            last_owner_reg <= last_owner_next;
        end
    end

    // Bus mux: only the requester actually accessing reaches the SRAM;
    // idle cycles present address 0, data 0, write disabled.
    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        assign addr_masked[gi]  = access_vec[gi] ? bus.Address[gi] : '0;
        assign wdata_masked[gi] = access_vec[gi] ? bus.Write_data[gi] : '0;
        assign write_vec[gi]    = access_vec[gi] & ~bus.We_n[gi];
        assign read_vec[gi]     = access_vec[gi] & bus.We_n[gi];
        assign bus.Read_valid[gi] = pop_valid && (pop_id == req_id_t'(gi));
    end

    assign bus.SRAM_address    = addr_masked[0] | addr_masked[1] | addr_masked[2];
    assign bus.SRAM_write_data = wdata_masked[0] | wdata_masked[1] | wdata_masked[2];
    assign bus.SRAM_we_n       = ~(|write_vec);
    assign bus.Grant           = grant_reg;
    assign bus.Read_data       = bus.SRAM_read_data;

    sram_read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk        (Clock),
        .srst       (Reset),
        .push_valid (|read_vec),
        .push_id    (owner_id),
        .pop_valid  (pop_valid),
        .pop_id     (pop_id)
    );

endmodule
